// File: rtl/conv_operand_store_pkg.sv
// Shared types and helpers for the convolution operand store.
package conv_pkg;

  localparam int unsigned DATA_SIZE_DEFAULT = 64;

  typedef logic [15:0] index_t;

  // Row-major linear address of [entry][y][x] in a plane of edge dim.
  function automatic int unsigned addr3(input int unsigned entry,
                                        input int unsigned y,
                                        input int unsigned x,
                                        input int unsigned dim);
    return (entry * dim + y) * dim + x;
  endfunction

endpackage

// File: rtl/conv_operand_store_if.sv
// Load/read bus between the layer controller (master) and the operand store (slave).
interface conv_operand_store_if
  import conv_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT
);

  logic                 act_write;
  logic [DATA_SIZE-1:0] act_in_data;
  index_t               act_index_entry, act_index_y, act_index_x;
  index_t               act_read_index_entry, act_read_index_y, act_read_index_x;
  logic [DATA_SIZE-1:0] act_out_data;

  logic                 weight_write;
  logic                 bias_write;
  logic [DATA_SIZE-1:0] w_in_data;
  index_t               w_index_in, w_index_out, w_index_k_y, w_index_k_x;
  index_t               w_read_index_in, w_read_index_out, w_read_index_y, w_read_index_x;
  index_t               w_read_index_bias;
  logic [DATA_SIZE-1:0] out_data_weight;
  logic [DATA_SIZE-1:0] out_data_bias;

  modport master (
    output act_write, act_in_data, act_index_entry, act_index_y, act_index_x,
           act_read_index_entry, act_read_index_y, act_read_index_x,
           weight_write, bias_write, w_in_data,
           w_index_in, w_index_out, w_index_k_y, w_index_k_x,
           w_read_index_in, w_read_index_out, w_read_index_y, w_read_index_x,
           w_read_index_bias,
    input  act_out_data, out_data_weight, out_data_bias
  );

  modport slave (
    input  act_write, act_in_data, act_index_entry, act_index_y, act_index_x,
           act_read_index_entry, act_read_index_y, act_read_index_x,
           weight_write, bias_write, w_in_data,
           w_index_in, w_index_out, w_index_k_y, w_index_k_x,
           w_read_index_in, w_read_index_out, w_read_index_y, w_read_index_x,
           w_read_index_bias,
    output act_out_data, out_data_weight, out_data_bias
  );

endinterface

// File: rtl/conv_operand_store_act_store.sv
// Generic [entry][y][x] word array: one write port, one asynchronous read port,
// per-field range checks so an out-of-range field never aliases into another word.
module act_store
  import conv_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int unsigned ENTRIES   = 1,
  parameter int unsigned DIM       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [DATA_SIZE-1:0] wdata_i,
  input  index_t               wr_entry_i,
  input  index_t               wr_y_i,
  input  index_t               wr_x_i,
  input  index_t               rd_entry_i,
  input  index_t               rd_y_i,
  input  index_t               rd_x_i,
  output logic [DATA_SIZE-1:0] rdata_o
);

  localparam int unsigned DEPTH = ENTRIES * DIM * DIM;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] mem_d [DEPTH];
  logic                 wr_ok, rd_ok;
  int unsigned          wr_addr, rd_addr;

  // Decode both addresses; each field is checked against its own dimension.
  always_comb begin
    wr_ok   = (32'(wr_entry_i) < ENTRIES) && (32'(wr_y_i) < DIM) && (32'(wr_x_i) < DIM);
    rd_ok   = (32'(rd_entry_i) < ENTRIES) && (32'(rd_y_i) < DIM) && (32'(rd_x_i) < DIM);
    wr_addr = addr3(32'(wr_entry_i), 32'(wr_y_i), 32'(wr_x_i), DIM);
    rd_addr = addr3(32'(rd_entry_i), 32'(rd_y_i), 32'(rd_x_i), DIM);
  end

  // Next contents: only the addressed word changes on a valid write.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // NOTE: every branch assigns mem_d[i], so no latch is inferred.
      if (we_i && wr_ok && wr_addr == i) mem_d[i] = wdata_i;
      else                               mem_d[i] = mem_q[i];
    end
  end

  // Storage update; reset clears every word and blocks that cycle's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is built from flops, not a RAM macro, because every word
      // must read 0 right after reset.
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so all words update together at the edge.
      mem_q <= mem_d;
    end
  end

  // Asynchronous read; an out-of-range field yields 0.
  always_comb begin
    rdata_o = '0;
    if (rd_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_addr == i) rdata_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/conv_operand_store.sv
// Operand store for one convolution layer: activation planes (act_store),
// [in][out][ky][kx] weights and a per-output bias vector, all with async reads.
module conv_operand_store
  import conv_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = DATA_SIZE_DEFAULT,
  parameter int unsigned ACT_DIM     = 5,
  parameter int unsigned ACT_ENTRIES = 1,
  parameter int unsigned NUM_INPUTS  = 1,
  parameter int unsigned NUM_OUTPUTS = 1,
  parameter int unsigned KERNEL_DIM  = 3
) (
  input logic                  clk,
  input logic                  rst,
  conv_operand_store_if.slave  bus
);

  localparam int unsigned W_DEPTH = NUM_INPUTS * NUM_OUTPUTS * KERNEL_DIM * KERNEL_DIM;

  act_store #(
    .DATA_SIZE (DATA_SIZE),
    .ENTRIES   (ACT_ENTRIES),
    .DIM       (ACT_DIM)
  ) u_act (
    .clk        (clk),
    .rst        (rst),
    .we_i       (bus.act_write),
    .wdata_i    (bus.act_in_data),
    .wr_entry_i (bus.act_index_entry),
    .wr_y_i     (bus.act_index_y),
    .wr_x_i     (bus.act_index_x),
    .rd_entry_i (bus.act_read_index_entry),
    .rd_y_i     (bus.act_read_index_y),
    .rd_x_i     (bus.act_read_index_x),
    .rdata_o    (bus.act_out_data)
  );

  logic [DATA_SIZE-1:0] w_q [W_DEPTH];
  logic [DATA_SIZE-1:0] w_d [W_DEPTH];
  logic [DATA_SIZE-1:0] b_q [NUM_OUTPUTS];
  logic [DATA_SIZE-1:0] b_d [NUM_OUTPUTS];
  logic                 w_wr_ok, w_rd_ok, b_wr_ok, b_rd_ok;
  int unsigned          w_wr_addr, w_rd_addr;

  // Weight/bias address decode; [in][out] collapses into the plane number.
  always_comb begin
    w_wr_ok = (32'(bus.w_index_in) < NUM_INPUTS) && (32'(bus.w_index_out) < NUM_OUTPUTS) &&
              (32'(bus.w_index_k_y) < KERNEL_DIM) && (32'(bus.w_index_k_x) < KERNEL_DIM);
    w_rd_ok = (32'(bus.w_read_index_in) < NUM_INPUTS) &&
              (32'(bus.w_read_index_out) < NUM_OUTPUTS) &&
              (32'(bus.w_read_index_y) < KERNEL_DIM) && (32'(bus.w_read_index_x) < KERNEL_DIM);
    b_wr_ok = 32'(bus.w_index_out) < NUM_OUTPUTS;
    b_rd_ok = 32'(bus.w_read_index_bias) < NUM_OUTPUTS;
    w_wr_addr = addr3(32'(bus.w_index_in) * NUM_OUTPUTS + 32'(bus.w_index_out),
                      32'(bus.w_index_k_y), 32'(bus.w_index_k_x), KERNEL_DIM);
    w_rd_addr = addr3(32'(bus.w_read_index_in) * NUM_OUTPUTS + 32'(bus.w_read_index_out),
                      32'(bus.w_read_index_y), 32'(bus.w_read_index_x), KERNEL_DIM);
  end

  // Next contents; weight and bias writes are independent and may coincide.
  always_comb begin
    for (int unsigned i = 0; i < W_DEPTH; i++) begin
      if (bus.weight_write && w_wr_ok && w_wr_addr == i) w_d[i] = bus.w_in_data;
      else                                               w_d[i] = w_q[i];
    end
    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      if (bus.bias_write && b_wr_ok && 32'(bus.w_index_out) == i) b_d[i] = bus.w_in_data;
      else                                                        b_d[i] = b_q[i];
    end
  end

  // Weight/bias storage with reset priority over writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < W_DEPTH; i++)     w_q[i] <= '0;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) b_q[i] <= '0;
    end else begin
      w_q <= w_d;
      b_q <= b_d;
    end
  end

  // Asynchronous weight and bias reads; out-of-range returns 0.
  always_comb begin
    bus.out_data_weight = '0;
    bus.out_data_bias   = '0;
    if (w_rd_ok) begin
      for (int unsigned i = 0; i < W_DEPTH; i++) begin
        if (w_rd_addr == i) bus.out_data_weight = w_q[i];
      end
    end
    if (b_rd_ok) begin
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
        if (32'(bus.w_read_index_bias) == i) bus.out_data_bias = b_q[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_operand_store.sv
// Self-checking bench for conv_operand_store: an array-level model indexed by
// the natural [entry][y][x] / [in][out][ky][kx] coordinates, a negedge compare
// process, directed scenarios with literal expectations, and random traffic.
module tb_conv_operand_store;
  import conv_pkg::*;

  localparam int DW  = 64;
  localparam int AD  = 5;   // ACT_DIM
  localparam int AE  = 2;   // ACT_ENTRIES
  localparam int NI  = 2;   // NUM_INPUTS
  localparam int NO  = 3;   // NUM_OUTPUTS
  localparam int KD  = 3;   // KERNEL_DIM

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_operand_store_if #(.DATA_SIZE(DW)) bus ();

  conv_operand_store #(
    .DATA_SIZE   (DW),
    .ACT_DIM     (AD),
    .ACT_ENTRIES (AE),
    .NUM_INPUTS  (NI),
    .NUM_OUTPUTS (NO),
    .KERNEL_DIM  (KD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model in natural coordinates.
  logic [DW-1:0] act_m [AE][AD][AD];
  logic [DW-1:0] w_m   [NI][NO][KD][KD];
  logic [DW-1:0] b_m   [NO];

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] act_exp(input index_t e, input index_t y, input index_t x);
    if (int'(e) < AE && int'(y) < AD && int'(x) < AD) return act_m[e][y][x];
    return '0;
  endfunction

  function automatic logic [DW-1:0] w_exp(input index_t i, input index_t o,
                                          input index_t y, input index_t x);
    if (int'(i) < NI && int'(o) < NO && int'(y) < KD && int'(x) < KD) return w_m[i][o][y][x];
    return '0;
  endfunction

  function automatic logic [DW-1:0] b_exp(input index_t o);
    if (int'(o) < NO) return b_m[o];
    return '0;
  endfunction

  // Apply to the model what the store must do at this edge.
  task automatic model_step();
    if (rst) begin
      for (int e = 0; e < AE; e++) for (int y = 0; y < AD; y++) for (int x = 0; x < AD; x++)
        act_m[e][y][x] = '0;
      for (int i = 0; i < NI; i++) for (int o = 0; o < NO; o++)
        for (int y = 0; y < KD; y++) for (int x = 0; x < KD; x++) w_m[i][o][y][x] = '0;
      for (int o = 0; o < NO; o++) b_m[o] = '0;
    end else begin
      if (bus.act_write && int'(bus.act_index_entry) < AE &&
          int'(bus.act_index_y) < AD && int'(bus.act_index_x) < AD)
        act_m[bus.act_index_entry][bus.act_index_y][bus.act_index_x] = bus.act_in_data;
      if (bus.weight_write && int'(bus.w_index_in) < NI && int'(bus.w_index_out) < NO &&
          int'(bus.w_index_k_y) < KD && int'(bus.w_index_k_x) < KD)
        w_m[bus.w_index_in][bus.w_index_out][bus.w_index_k_y][bus.w_index_k_x] = bus.w_in_data;
      if (bus.bias_write && int'(bus.w_index_out) < NO)
        b_m[bus.w_index_out] = bus.w_in_data;
    end
  endtask

  // One clock: model follows the edge, then return just after the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Continuous comparison of all three read ports against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("act_read", bus.act_out_data,
            act_exp(bus.act_read_index_entry, bus.act_read_index_y, bus.act_read_index_x));
      check("weight_read", bus.out_data_weight,
            w_exp(bus.w_read_index_in, bus.w_read_index_out, bus.w_read_index_y, bus.w_read_index_x));
      check("bias_read", bus.out_data_bias, b_exp(bus.w_read_index_bias));
    end
  end

  function automatic index_t rnd_idx(input int dim);
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 16'hFFFF;
    if (r == 1) return 16'(dim);
    return 16'($urandom_range(0, dim - 1));
  endfunction

  task automatic set_act_rd(input int e, input int y, input int x);
    bus.act_read_index_entry = 16'(e);
    bus.act_read_index_y     = 16'(y);
    bus.act_read_index_x     = 16'(x);
  endtask

  task automatic set_act_wr(input int e, input int y, input int x, input logic [DW-1:0] d);
    bus.act_index_entry = 16'(e);
    bus.act_index_y     = 16'(y);
    bus.act_index_x     = 16'(x);
    bus.act_in_data     = d;
    bus.act_write       = 1'b1;
  endtask

  task automatic set_w_rd(input int i, input int o, input int y, input int x);
    bus.w_read_index_in  = 16'(i);
    bus.w_read_index_out = 16'(o);
    bus.w_read_index_y   = 16'(y);
    bus.w_read_index_x   = 16'(x);
  endtask

  task automatic set_w_wr(input int i, input int o, input int y, input int x);
    bus.w_index_in  = 16'(i);
    bus.w_index_out = 16'(o);
    bus.w_index_k_y = 16'(y);
    bus.w_index_k_x = 16'(x);
  endtask

  initial begin
    rst = 1'b1;
    bus.act_write = 1'b0; bus.act_in_data = '0;
    set_act_wr(0, 0, 0, '0); bus.act_write = 1'b0;
    set_act_rd(0, 0, 0);
    bus.weight_write = 1'b0; bus.bias_write = 1'b0; bus.w_in_data = '0;
    set_w_wr(0, 0, 0, 0); set_w_rd(0, 0, 0, 0); bus.w_read_index_bias = '0;

    // Reset, then everything reads 0.
    tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    tick();
    check("reset_act", bus.act_out_data, 64'h0);
    check("reset_weight", bus.out_data_weight, 64'h0);
    check("reset_bias", bus.out_data_bias, 64'h0);

    // Activation write of 1.5 at [0][2][3]; transposed address stays 0.
    set_act_wr(0, 2, 3, 64'h3FF8000000000000);
    set_act_rd(0, 2, 3);
    tick();
    bus.act_write = 1'b0;
    check("act_write_1p5", bus.act_out_data, 64'h3FF8000000000000);
    set_act_rd(0, 3, 2);
    #1 check("act_transposed_zero", bus.act_out_data, 64'h0);

    // Simultaneous weight and bias write with shared data.
    set_w_wr(0, 0, 2, 1);
    bus.w_in_data = 64'h4000000000000000;
    bus.weight_write = 1'b1; bus.bias_write = 1'b1;
    set_w_rd(0, 0, 2, 1); bus.w_read_index_bias = 16'd0;
    tick();
    bus.weight_write = 1'b0; bus.bias_write = 1'b0;
    check("weight_2p0", bus.out_data_weight, 64'h4000000000000000);
    check("bias_2p0", bus.out_data_bias, 64'h4000000000000000);

    // Out-of-range y must neither write nor alias into [1][0][0].
    set_act_wr(0, 0, 0, 64'h1234);
    tick();
    set_act_wr(0, 5, 0, 64'hDEAD);
    set_act_rd(0, 5, 0);
    tick();
    bus.act_write = 1'b0;
    check("act_y5_read_zero", bus.act_out_data, 64'h0);
    set_act_rd(0, 0, 0);
    #1 check("act_000_unchanged", bus.act_out_data, 64'h1234);
    set_act_rd(1, 0, 0);
    #1 check("act_no_alias_100", bus.act_out_data, 64'h0);

    // Read-during-write: old word before the edge, new word after.
    set_act_wr(0, 1, 1, 64'hA);
    set_act_rd(0, 1, 1);
    tick();
    set_act_wr(0, 1, 1, 64'hB);
    #1 check("rdw_before_edge", bus.act_out_data, 64'hA);
    tick();
    bus.act_write = 1'b0;
    check("rdw_after_edge", bus.act_out_data, 64'hB);

    // Random traffic, including occasional reset and out-of-range fields.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.act_write = $urandom_range(0, 1) == 1;
      bus.act_in_data = {$urandom(), $urandom()};
      bus.act_index_entry = rnd_idx(AE); bus.act_index_y = rnd_idx(AD); bus.act_index_x = rnd_idx(AD);
      bus.act_read_index_entry = rnd_idx(AE);
      bus.act_read_index_y = rnd_idx(AD); bus.act_read_index_x = rnd_idx(AD);
      bus.weight_write = $urandom_range(0, 1) == 1;
      bus.bias_write = $urandom_range(0, 2) == 0;
      bus.w_in_data = {$urandom(), $urandom()};
      bus.w_index_in = rnd_idx(NI); bus.w_index_out = rnd_idx(NO);
      bus.w_index_k_y = rnd_idx(KD); bus.w_index_k_x = rnd_idx(KD);
      bus.w_read_index_in = rnd_idx(NI); bus.w_read_index_out = rnd_idx(NO);
      bus.w_read_index_y = rnd_idx(KD); bus.w_read_index_x = rnd_idx(KD);
      bus.w_read_index_bias = rnd_idx(NO);
      tick();
    end
    rst = 1'b0;
    bus.act_write = 1'b0; bus.weight_write = 1'b0; bus.bias_write = 1'b0;

    // Fill every word with nonzero data.
    for (int e = 0; e < AE; e++) for (int y = 0; y < AD; y++) for (int x = 0; x < AD; x++) begin
      set_act_wr(e, y, x, {32'hAC7, 16'(e), 8'(y), 8'(x)});
      tick();
    end
    bus.act_write = 1'b0;
    for (int i = 0; i < NI; i++) for (int o = 0; o < NO; o++)
      for (int y = 0; y < KD; y++) for (int x = 0; x < KD; x++) begin
        set_w_wr(i, o, y, x);
        bus.w_in_data = {32'hBEEF, 8'(i), 8'(o), 8'(y), 8'(x)};
        bus.weight_write = 1'b1; bus.bias_write = 1'b1;
        tick();
      end
    bus.weight_write = 1'b0; bus.bias_write = 1'b0;
    set_act_rd(1, 4, 4);
    #1 check("fill_act_last", bus.act_out_data, {32'hAC7, 16'd1, 8'd4, 8'd4});

    // One reset cycle with a write pending: everything must clear.
    rst = 1'b1;
    set_act_wr(0, 1, 1, 64'hFFFF);
    tick();
    rst = 1'b0;
    bus.act_write = 1'b0;
    set_act_rd(0, 1, 1);
    #1 check("blocked_write_zero", bus.act_out_data, 64'h0);
    for (int e = 0; e < AE; e++) for (int y = 0; y < AD; y++) for (int x = 0; x < AD; x++) begin
      set_act_rd(e, y, x);
      #1 check("post_reset_act", bus.act_out_data, 64'h0);
    end
    for (int i = 0; i < NI; i++) for (int o = 0; o < NO; o++)
      for (int y = 0; y < KD; y++) for (int x = 0; x < KD; x++) begin
        set_w_rd(i, o, y, x);
        bus.w_read_index_bias = 16'(o);
        #1;
        check("post_reset_weight", bus.out_data_weight, 64'h0);
        check("post_reset_bias", bus.out_data_bias, 64'h0);
      end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_operand_store.md
# conv_operand_store

Operand storage for one convolution layer: an activation array indexed [entry][y][x] and a weight array indexed [in][out][ky][kx] plus a per-output bias vector. The layer controller loads all three through indexed write ports, then reads them through independent indexed read ports while it sequences the multiply-accumulate. Data words are opaque DATA_SIZE-bit values (IEEE-754 doubles in the layer) and are never interpreted here.

## Interface

- DATA_SIZE, 64: word width.
- ACT_DIM, 5: activation plane edge, so y and x run 0..ACT_DIM-1.
- ACT_ENTRIES, 1: number of activation planes.
- NUM_INPUTS, 1: number of weight input channels.
- NUM_OUTPUTS, 1: number of weight output channels, which is also the bias depth.
- KERNEL_DIM, 3: kernel edge.
- DEBUG, 0: when nonzero, simulation-only $display of each write, prefixed by NAME.
- NAME, "CONV_OPERAND_STORE": debug prefix string.

Ports:

- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- act_write in 1: write enable for the activation array.
- act_in_data in DATA_SIZE: activation write data.
- act_index_entry / act_index_y / act_index_x in 16 each: activation write address.
- act_read_index_entry / act_read_index_y / act_read_index_x in 16 each: activation read address.
- act_out_data out DATA_SIZE: activation read data.
- weight_write in 1: weight write enable.
- bias_write in 1: bias write enable.
- w_in_data in DATA_SIZE: shared write data for weights and bias.
- w_index_in / w_index_out / w_index_k_y / w_index_k_x in 16 each: weight write address. The bias write address is w_index_out.
- w_read_index_in / w_read_index_out / w_read_index_y / w_read_index_x in 16 each: weight read address.
- w_read_index_bias in 16: bias read address.
- out_data_weight out DATA_SIZE: weight read data.
- out_data_bias out DATA_SIZE: bias read data.

## Operation

- Activation array: ACT_ENTRIES*ACT_DIM*ACT_DIM words. Linear address = (entry*ACT_DIM + y)*ACT_DIM + x.
- Weight array: NUM_INPUTS*NUM_OUTPUTS*KERNEL_DIM² words. Linear address = ((in*NUM_OUTPUTS + out)*KERNEL_DIM + ky)*KERNEL_DIM + kx.
- Bias array: NUM_OUTPUTS words.
- Writes: when an enable is high at a rising clk edge, the addressed word takes the write data.
- weight_write and bias_write may be high together. Both writes happen, using the same w_in_data.
- Activation writes and weight/bias writes are fully independent.
- Reads are combinational (asynchronous). Each output reflects its read address and the current contents in the same cycle.
- Out of range: a write with any index field ≥ its dimension is ignored. A read with any index field out of range returns 0.
- Index fields are range-checked individually. An out-of-range field must never alias into another word.
- Reset: while rst is high at a clk edge, every word of all three arrays clears to 0, and writes in that cycle are ignored (reset has priority).
- Reset values of outputs: after reset, act_out_data, out_data_weight and out_data_bias read 0 for any address.

## Timing

- Write latency is 1 edge. Read latency is 0; the outputs follow the address combinationally.
- Read-during-write to the same address: before the edge, the output shows the old word. After the edge, it shows the new word. There is no bypass.
- The controller updates read indices on one edge and consumes the read data on the next edge. The combinational read path must therefore settle within one cycle.
- Reset asserted mid-load discards all prior contents. A load sequence must be restarted after reset.

## Structure

- Package conv_pkg holds:
  - the DATA_SIZE default;
  - an index_t typedef (16-bit);
  - a linear-address helper function addr3(entry, y, x, dim).
- Sub-module act_store holds the generic 3-D indexed array: write port, async read port, range checks and reset. It is instantiated once for activations.
- The weight/bias arrays live in the top level, or in a second instance-free block within the same file.

## Test plan

- Reset, then read act[0][0][0], weight[0][0][0][0] and bias[0] → all outputs 0.
- Write act[0][2][3] = 0x3FF8000000000000 (1.5), then set the read address to [0][2][3] → act_out_data equals 0x3FF8000000000000 one edge later. Address [0][3][2] still reads 0.
- Write weight[0][0][2][1] = 0x4000000000000000 with weight_write and bias_write both high, w_index_out = 0 → weight[0][0][2][1] and bias[0] both read 0x4000000000000000.
- Write act[0][5][0] with ACT_DIM=5 → ignored. Reading index y=5 returns 0, and act[0][0][0] is unchanged.
- Read-during-write: read address held at act[0][1][1] = 0xA, then write 0xB to it. The output is 0xA before the edge and 0xB after.
- Fill all words, assert rst for one cycle while act_write is high → every word reads 0, including the word targeted by the blocked write.
